// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view; the stream source and memory side take the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed, checksummed byte
// stream into big-endian words and keeps the processor in reset until it succeeds.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [ADDR_W:0] WORD_ONE  = 1;
  localparam logic [15:0]     DEPTH_LIM = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [ADDR_W:0]   wordIdx_q, wordIdx_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       asm_q, asm_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpuReset_q, cpuReset_d;

  logic              inReady;
  logic              accept;
  logic [15:0]       headerN;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byteIdx_d  = byteIdx_q;
    wordIdx_d  = wordIdx_q;
    sum_d      = sum_q;
    asm_d      = asm_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    done_d     = done_q;
    error_d    = error_q;
    cpuReset_d = cpuReset_q;

    inReady = (state_q != DONE) && (state_q != ERR);
    accept  = bus.in_valid && inReady;
    headerN = {count_q[15:8], bus.in_data};

    // The checksum covers every byte before the checksum byte itself.
    if (accept && state_q != CSUM) begin
      sum_d = sum_q + bus.in_data;
    end

    case (state_q)
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = bus.in_data;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = headerN;
          if (headerN > DEPTH_LIM) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (headerN == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d     = {asm_q[23:0], bus.in_data};
          byteIdx_d = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'd3) begin
            memWe_d    = 1'b1;
            memAddr_d  = wordIdx_q[ADDR_W-1:0];
            memWdata_d = {asm_q[23:0], bus.in_data};
            wordIdx_d  = wordIdx_q + WORD_ONE;
            if (16'(wordIdx_q) + 16'd1 == count_q) begin
              state_d = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (bus.in_data == sum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpuReset_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HDR_HI;
      count_q    <= '0;
      byteIdx_q  <= '0;
      wordIdx_q  <= '0;
      sum_q      <= '0;
      asm_q      <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpuReset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byteIdx_q  <= byteIdx_d;
      wordIdx_q  <= wordIdx_d;
      sum_q      <= sum_d;
      asm_q      <= asm_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpuReset_q <= cpuReset_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.cpu_reset = cpuReset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random streams compared
// against a stream-level reference model of the expected writes and final status.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk;
  logic reset;

  imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]          stim[$];
  logic [ADDR_W+31:0]  expWrites[$];
  logic [ADDR_W+31:0]  obsWrites[$];
  bit                  expDone;
  bit                  expError;

  int cyc    = 0;
  int lastWe = -100;
  int weViol = 0;

  // Capture every write pulse and flag any two pulses closer than four cycles.
  always @(negedge clk) begin
    cyc++;
    if (ifc.mem_we === 1'b1) begin
      if (cyc - lastWe < 4) weViol++;
      lastWe = cyc;
      obsWrites.push_back({ifc.mem_addr, ifc.mem_wdata});
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: derive writes and outcome from the stream format rules.
  task automatic modelStream();
    int n;
    int sum;
    logic [31:0] w;
    expWrites.delete();
    expDone  = 0;
    expError = 0;
    n   = int'(stim[0]) * 256 + int'(stim[1]);
    sum = int'(stim[0]) + int'(stim[1]);
    if (n > DEPTH) begin
      expError = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
        for (int k = 0; k < 4; k++) sum += int'(stim[2+4*i+k]);
        expWrites.push_back({ADDR_W'(i), w});
      end
      if (sum % 256 == int'(stim[2+4*n])) expDone = 1;
      else expError = 1;
    end
  endtask

  task automatic buildRandom(input int n, input bit corrupt);
    int sum;
    stim.delete();
    stim.push_back(8'(n / 256));
    stim.push_back(8'(n % 256));
    sum = n / 256 + n % 256;
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) begin
        stim.push_back(8'($urandom_range(0, 255)));
        sum += int'(stim[stim.size()-1]);
      end
      if (corrupt) stim.push_back(8'((sum + $urandom_range(1, 255)) % 256));
      else stim.push_back(8'(sum % 256));
    end
  endtask

  task automatic loadTwoWord(input logic [7:0] lastByte);
    stim = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, lastByte};
  endtask

  task automatic doReset();
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    obsWrites.delete();
  endtask

  // Sends stim with random idle gaps; stops early if the loader stops accepting.
  task automatic sendStream(input int maxGap, output int cycles);
    int gap;
    cycles = 0;
    foreach (stim[i]) begin
      gap = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
      repeat (gap) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        cycles++;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = stim[i];
      @(negedge clk);
      if (ifc.in_ready !== 1'b1) break;
      @(posedge clk);
      #1;
      cycles++;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int maxGap, output int cycles);
    modelStream();
    sendStream(maxGap, cycles);
  endtask

  task automatic test_reset();
    doReset();
    vectors += 7;
    if (ifc.mem_we !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b want 0", ifc.mem_we); end
    if (ifc.mem_addr !== '0)     begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %0d want 0", ifc.mem_addr); end
    if (ifc.mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", ifc.mem_wdata); end
    if (ifc.cpu_reset !== 1'b1)  begin miscompares++; $display("[TB] FAIL reset_cpu_reset: got %b want 1", ifc.cpu_reset); end
    if (ifc.done !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", ifc.done); end
    if (ifc.error !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_error: got %b want 0", ifc.error); end
    if (ifc.in_ready !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
  endtask

  task automatic test_two_word();
    int cycles;
    doReset();
    loadTwoWord(8'h58);
    applyStimulus(0, cycles);
    vectors += 3;
    if (ifc.done !== expDone)       begin miscompares++; $display("[TB] FAIL two_word_done: got %b want %b", ifc.done, expDone); end
    if (ifc.cpu_reset !== expError) begin miscompares++; $display("[TB] FAIL two_word_cpu_reset: got %b want %b", ifc.cpu_reset, expError); end
    if (ifc.error !== expError)     begin miscompares++; $display("[TB] FAIL two_word_error: got %b want %b", ifc.error, expError); end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obsWrites.size() != expWrites.size()) begin
      miscompares++;
      $display("[TB] FAIL two_word_write_count: got %0d want %0d", obsWrites.size(), expWrites.size());
    end else begin
      foreach (expWrites[i]) begin
        vectors++;
        if (obsWrites[i] !== expWrites[i]) begin
          miscompares++;
          $display("[TB] FAIL two_word_write%0d: got %h want %h", i, obsWrites[i], expWrites[i]);
        end
      end
    end
  endtask

  task automatic test_bad_checksum();
    int cycles;
    doReset();
    loadTwoWord(8'h59);
    applyStimulus(0, cycles);
    repeat (2) @(posedge clk);
    #1;
    vectors += 5;
    if (ifc.error !== expError)       begin miscompares++; $display("[TB] FAIL bad_csum_error: got %b want %b", ifc.error, expError); end
    if (ifc.done !== expDone)         begin miscompares++; $display("[TB] FAIL bad_csum_done: got %b want %b", ifc.done, expDone); end
    if (ifc.cpu_reset !== 1'b1)       begin miscompares++; $display("[TB] FAIL bad_csum_cpu_reset: got %b want 1", ifc.cpu_reset); end
    if (ifc.in_ready !== 1'b0)        begin miscompares++; $display("[TB] FAIL bad_csum_in_ready: got %b want 0", ifc.in_ready); end
    if (obsWrites.size() != expWrites.size()) begin
      miscompares++;
      $display("[TB] FAIL bad_csum_write_count: got %0d want %0d", obsWrites.size(), expWrites.size());
    end else begin
      foreach (expWrites[i]) begin
        vectors++;
        if (obsWrites[i] !== expWrites[i]) begin
          miscompares++;
          $display("[TB] FAIL bad_csum_write%0d: got %h want %h", i, obsWrites[i], expWrites[i]);
        end
      end
    end
  endtask

  task automatic test_empty();
    int cycles;
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      stim = '{8'h00, 8'h00, 8'h00};
      if (pass == 1) stim[2] = 8'h01;
      applyStimulus(0, cycles);
      vectors += 3;
      if (ifc.done !== expDone)   begin miscompares++; $display("[TB] FAIL empty%0d_done: got %b want %b", pass, ifc.done, expDone); end
      if (ifc.error !== expError) begin miscompares++; $display("[TB] FAIL empty%0d_error: got %b want %b", pass, ifc.error, expError); end
      repeat (2) @(posedge clk);
      #1;
      if (obsWrites.size() != 0)  begin miscompares++; $display("[TB] FAIL empty%0d_writes: got %0d want 0", pass, obsWrites.size()); end
    end
  endtask

  task automatic test_oversize();
    int cycles;
    int notReady = 0;
    doReset();
    stim = '{8'h00, 8'h41};
    applyStimulus(0, cycles);
    vectors += 2;
    if (ifc.error !== expError) begin miscompares++; $display("[TB] FAIL oversize_error: got %b want %b", ifc.error, expError); end
    if (ifc.in_ready !== 1'b0)  begin miscompares++; $display("[TB] FAIL oversize_in_ready: got %b want 0", ifc.in_ready); end
    repeat (10) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (ifc.in_ready === 1'b0) notReady++;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors += 3;
    if (notReady != 10)        begin miscompares++; $display("[TB] FAIL oversize_held_ready: got %0d low cycles want 10", notReady); end
    if (obsWrites.size() != 0) begin miscompares++; $display("[TB] FAIL oversize_writes: got %0d want 0", obsWrites.size()); end
    if (ifc.error !== 1'b1)    begin miscompares++; $display("[TB] FAIL oversize_error_sticky: got %b want 1", ifc.error); end
  endtask

  task automatic test_gaps();
    int cycles;
    int notReady = 0;
    int writesBefore;
    doReset();
    loadTwoWord(8'h58);
    applyStimulus(5, cycles);
    vectors += 2;
    if (ifc.done !== expDone)   begin miscompares++; $display("[TB] FAIL gaps_done: got %b want %b", ifc.done, expDone); end
    if (ifc.error !== expError) begin miscompares++; $display("[TB] FAIL gaps_error: got %b want %b", ifc.error, expError); end
    repeat (2) @(posedge clk);
    #1;
    writesBefore = obsWrites.size();
    vectors++;
    if (obsWrites.size() != expWrites.size()) begin
      miscompares++;
      $display("[TB] FAIL gaps_write_count: got %0d want %0d", obsWrites.size(), expWrites.size());
    end else begin
      foreach (expWrites[i]) begin
        vectors++;
        if (obsWrites[i] !== expWrites[i]) begin
          miscompares++;
          $display("[TB] FAIL gaps_write%0d: got %h want %h", i, obsWrites[i], expWrites[i]);
        end
      end
    end
    ifc.in_valid = 1'b1;
    repeat (8) begin
      ifc.in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (ifc.in_ready === 1'b0) notReady++;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors += 3;
    if (notReady != 8)                    begin miscompares++; $display("[TB] FAIL gaps_after_done_ready: got %0d low cycles want 8", notReady); end
    if (obsWrites.size() != writesBefore) begin miscompares++; $display("[TB] FAIL gaps_after_done_writes: got %0d want %0d", obsWrites.size(), writesBefore); end
    if (ifc.done !== 1'b1)                begin miscompares++; $display("[TB] FAIL gaps_done_sticky: got %b want 1", ifc.done); end
  endtask

  task automatic test_reset_midload();
    int cycles;
    doReset();
    loadTwoWord(8'h58);
    stim = stim[0:6];
    sendStream(0, cycles);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    obsWrites.delete();
    vectors += 5;
    if (ifc.cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_cpu_reset: got %b want 1", ifc.cpu_reset); end
    if (ifc.done !== 1'b0)      begin miscompares++; $display("[TB] FAIL midreset_done: got %b want 0", ifc.done); end
    if (ifc.error !== 1'b0)     begin miscompares++; $display("[TB] FAIL midreset_error: got %b want 0", ifc.error); end
    if (ifc.in_ready !== 1'b1)  begin miscompares++; $display("[TB] FAIL midreset_in_ready: got %b want 1", ifc.in_ready); end
    if (ifc.mem_we !== 1'b0)    begin miscompares++; $display("[TB] FAIL midreset_mem_we: got %b want 0", ifc.mem_we); end
    loadTwoWord(8'h58);
    applyStimulus(0, cycles);
    repeat (2) @(posedge clk);
    #1;
    vectors += 2;
    if (ifc.done !== expDone) begin miscompares++; $display("[TB] FAIL midreset_reload_done: got %b want %b", ifc.done, expDone); end
    if (obsWrites.size() != expWrites.size()) begin
      miscompares++;
      $display("[TB] FAIL midreset_write_count: got %0d want %0d", obsWrites.size(), expWrites.size());
    end else begin
      foreach (expWrites[i]) begin
        vectors++;
        if (obsWrites[i] !== expWrites[i]) begin
          miscompares++;
          $display("[TB] FAIL midreset_write%0d: got %h want %h", i, obsWrites[i], expWrites[i]);
        end
      end
    end
  endtask

  // Random lengths (including the full-depth and just-oversize boundaries) and checksums.
  task automatic test_random(input int maxGap, input string tag);
    int cycles;
    int n;
    bit corrupt;
    for (int t = 0; t < 8; t++) begin
      doReset();
      case (t)
        0:       n = DEPTH;
        1:       n = DEPTH + 1;
        2:       n = 1;
        default: n = $urandom_range(0, 12);
      endcase
      corrupt = ($urandom_range(0, 3) == 0);
      buildRandom(n, corrupt);
      applyStimulus(maxGap, cycles);
      repeat (2) @(posedge clk);
      #1;
      vectors += 4;
      if (ifc.done !== expDone)       begin miscompares++; $display("[TB] FAIL %s%0d_done: n=%0d got %b want %b", tag, t, n, ifc.done, expDone); end
      if (ifc.error !== expError)     begin miscompares++; $display("[TB] FAIL %s%0d_error: n=%0d got %b want %b", tag, t, n, ifc.error, expError); end
      if (ifc.cpu_reset !== !expDone) begin miscompares++; $display("[TB] FAIL %s%0d_cpu_reset: n=%0d got %b want %b", tag, t, n, ifc.cpu_reset, !expDone); end
      if (maxGap == 0 && cycles != stim.size()) begin
        miscompares++;
        $display("[TB] FAIL %s%0d_no_bubbles: n=%0d got %0d cycles want %0d", tag, t, n, cycles, stim.size());
      end
      if (obsWrites.size() != expWrites.size()) begin
        miscompares++;
        $display("[TB] FAIL %s%0d_write_count: n=%0d got %0d want %0d", tag, t, n, obsWrites.size(), expWrites.size());
      end else begin
        foreach (expWrites[i]) begin
          vectors++;
          if (obsWrites[i] !== expWrites[i]) begin
            miscompares++;
            $display("[TB] FAIL %s%0d_write%0d: got %h want %h", tag, t, i, obsWrites[i], expWrites[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(0, "b2b");
    vectors++;
    if (weViol != 0) begin miscompares++; $display("[TB] FAIL write_spacing: got %0d violations want 0", weViol); end
  endtask

  initial begin
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_empty();
    test_oversize();
    test_gaps();
    test_reset_midload();
    test_random(4, "rand");
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the processor only reads.
- Receives a byte stream through a valid/ready handshake, checks a header and checksum, and assembles big-endian 32-bit words (MSB byte first, matching memfile word order).
- Writes the words to the instruction-memory write port.
- Holds the processor in reset until a load completes cleanly.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory
- ADDR_W, 6, word-address width; must equal clog2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset (reset==0 resets the block on the next rising edge of clk)
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  assembled instruction word
- cpu_reset  output  1  active-high reset to the processor
- done  output  1  load completed, checksum good
- error  output  1  load aborted (length or checksum)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=HDR_HI; mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - Word count, byte index, word index and checksum are cleared.
  - A reset mid-load discards all progress. Words already written stay in memory.
- Byte transfer: a byte is accepted on a clk edge where in_valid & in_ready.
  - in_ready is combinational from state: 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in DONE and ERR.
  - in_valid may drop between bytes; a gap has no effect.
- Stream format: N_hi, N_lo (16-bit word count N, big-endian), then 4*N data bytes, then 1 checksum byte.
- Checksum: 8-bit modulo-256 sum of every byte before the checksum byte (both header bytes and all data bytes).
- States:
  - HDR_HI: accept byte -> store N[15:8] -> HDR_LO.
  - HDR_LO: accept byte -> store N[7:0].
    - If N > DEPTH -> ERR.
    - Else if N == 0 -> CSUM.
    - Else -> DATA.
  - DATA: shift each accepted byte into a 32-bit assembly register, MSB first; byte index counts 0..3.
    - On acceptance of byte index 3, the next cycle has mem_we=1, mem_addr=word index, mem_wdata=assembled word.
    - The word index then increments.
    - After word N-1 is accepted -> CSUM. The write pulse still occurs on the following cycle.
  - CSUM: accept byte.
    - Equal to the running sum -> DONE.
    - Otherwise -> ERR.
  - DONE: done=1, cpu_reset=0. Stays here until reset; further input is ignored.
  - ERR: error=1, cpu_reset stays 1. Stays here until reset; further input is ignored.
- Registered outputs: mem_we, mem_addr, mem_wdata, done, error and cpu_reset are all registered.
  - mem_we is never high two consecutive cycles.
  - Minimum spacing between writes is 4 cycles.
- Timing: done/cpu_reset change on the edge that accepts the checksum byte, so they are visible the following cycle.
- Word index width is ADDR_W+1 so that N == DEPTH loads every address without wrap. No address beyond DEPTH-1 is ever written.
- Data written before a checksum failure remains in memory. The processor is not released.
- Back-to-back bytes with in_valid held high load one byte per cycle with no bubbles.

Test Plan:
- Two-word load, stream 00 02 20 02 00 05 20 03 00 0C 58, in_valid held high:
  - mem_we pulses with addr 0 / data 0x20020005, then addr 1 / data 0x2003000C.
  - done=1, cpu_reset=0, error=0 the cycle after byte 0x58 is accepted.
- Same stream with last byte 0x59:
  - both writes still occur.
  - error=1, done=0, cpu_reset stays 1, in_ready=0.
- Empty load, stream 00 00 00:
  - no mem_we pulse; done=1 after the third byte.
  - Stream 00 00 01 instead: error=1.
- Oversize header with DEPTH=64, stream 00 41:
  - error=1 after the second byte; in_ready=0.
  - 10 further valid bytes produce no writes.
- First stream of the two-word load with in_valid randomly deasserted (gaps of 0-5 cycles):
  - identical writes and final done to the two-word load case.
  - After done, holding in_valid=1 gives in_ready=0 and no mem_we.
- Reset mid-load:
  - Drive reset=0 for one cycle after 5 data bytes: state returns to HDR_HI, cpu_reset=1, done=error=0.
  - Then send the full two-word load stream: completes with done=1 and both correct writes.
